seq_slice_alu: RTL and testbench
================================

# seq_slice_alu

Parametrised, sequential successor to the 4-bit S/M/Cin ALU. It executes the same 16 logic and 16 arithmetic functions on WIDTH-bit operands. Each operation runs one SLICE-bit slice per clock, LSB slice first, with the carry held in a register between slices. Operands enter and results leave through valid/ready handshakes. The block also keeps a stored carry flag so that successive operations can be chained for multi-precision arithmetic.

## Interface
- WIDTH, 16: operand width. Must be a positive multiple of SLICE; any other value is an elaboration error.
- SLICE, 4: bits processed per cycle.
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept a request (high only in IDLE)
- a, b  in  WIDTH  operands
- s  in  4  function select (s[0]..s[3])
- m  in  1  1 = logic mode, 0 = arithmetic mode
- cin  in  1  active-high carry-in (1 adds one)
- use_cf  in  1  1 = take carry-in from the stored carry flag cf instead of cin
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- f  out  WIDTH  result
- cout  out  1  carry out of the MSB (0 in logic mode)
- zero  out  1  f == 0
- ovf  out  1  signed overflow (0 in logic mode)

## Operation
- Per-bit terms:
  - t1 = a | (s[0]&b) | (s[1]&~b)
  - t2 = (s[2]&a&~b) | (s[3]&a&b)
- Logic mode (m=1): f = ~(t1 ^ t2). No carry is used.
- Arithmetic mode (m=0): f = t1 + t2 + c0, with each slice's carry-out feeding the next slice.
  - Example encodings: s=1001 gives A+B; s=0110 gives A−B−1; s=1111 gives A−1; s=0011 gives −1; s=1100 gives A+A.
- c0 = use_cf ? cf : cin.
- ovf = (carry into MSB) ^ cout, arithmetic mode only.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid, latch a, b, s, m and c0, clear the slice index idx, go to RUN.
  - RUN: each cycle compute slice idx, write f[idx*SLICE +: SLICE] and update the carry register. When idx = WIDTH/SLICE−1, register cout/zero/ovf and go to DONE; otherwise idx increments.
  - DONE: out_valid=1. f and the flags are held stable. On out_ready, go to IDLE and update cf.
- Stored carry flag cf:
  - Updated to cout only when an arithmetic operation completes its output handshake.
  - Unchanged by logic operations.
- in_valid is ignored outside IDLE. Latched operands are unaffected by input changes after acceptance.

## Timing
- Reset (async assert, sync-safe release):
  - State returns to IDLE.
  - f=0, cout=0, zero=0, ovf=0, out_valid=0, cf=0, carry register=0, idx=0.
  - in_ready=1 after reset (IDLE).
- Request acceptance occurs at rising edge E0 where in_valid & in_ready.
- With N = WIDTH/SLICE, slices are computed at edges E1..EN. out_valid rises after EN, i.e. N cycles after E0.
- The result handshake occurs at the edge where out_valid & out_ready. in_ready returns high the following cycle, so the minimum issue interval is N+2 cycles.
- f bits change only during RUN and are never visible as valid mid-operation.
- Backpressure: DONE holds indefinitely with outputs stable. in_ready stays 0 throughout.
- Reset asserted during RUN or DONE aborts the operation immediately. No out_valid is produced and cf is cleared.
- With WIDTH = SLICE (N=1), the operation is accepted at E0, computed at E1, and out_valid rises after E1.

## Test plan
- Add, WIDTH=16: a=0x1234, b=0x0FFF, s=1001, m=0, cin=0 → f=0x2233, cout=0, zero=0, ovf=0. out_valid rises exactly 4 cycles after acceptance.
- Subtract: s=0110, cin=1, a=0x0005, b=0x0007 → f=0xFFFE, cout=0, ovf=0.
  - Then a=0x7FFF, b=0xFFFF → f=0x8000, cout=0, ovf=1.
- Chained 32-bit add, first op: a=0xFFFF, b=0x0001, s=1001, cin=0 → f=0x0000, cout=1, zero=1.
  - Second op: a=0, b=0, use_cf=1 → f=0x0001, cout=0.
- Logic: m=1, s=0110, a=0xF0F0, b=0xFF00 → f=0x0FF0, cout=0, ovf=0.
  - A following add with use_cf=1 shows cf unchanged from the prior arithmetic op.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid → f and flags stable, in_ready=0, pulses on in_valid ignored. After out_ready=1, exactly one result is consumed and in_ready=1 next cycle.
- Reset mid-operation: drop rst_n during slice 2 of an add → out_valid=0, f=0, cf=0 immediately. After release, the next request a=0x0001, b=0x0001, s=1001 → f=0x0002.

Source files
------------

// File: rtl/seq_slice_alu_if.sv
// Handshake and data bus of seq_slice_alu: request side (operands, function
// select, carry controls) and result side (result plus status flags).
interface seq_slice_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       s;
  logic             m;
  logic             cin;
  logic             use_cf;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, s, m, cin, use_cf, out_ready,
    input  in_ready, out_valid, f, cout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, s, m, cin, use_cf, out_ready,
    output in_ready, out_valid, f, cout, zero, ovf
  );
endinterface

// File: rtl/seq_slice_alu.sv
// Sequential S/M/Cin ALU: processes one SLICE-bit slice per clock, LSB first,
// with a registered inter-slice carry and a stored carry flag for chaining.
module seq_slice_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_slice_alu_if.slave bus
);

  if ((SLICE == 0) || (WIDTH == 0) || ((WIDTH % SLICE) != 0)) begin : g_param_check
    $error("seq_slice_alu: WIDTH must be a positive multiple of SLICE");
  end

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] f_r;
  logic [3:0]       s_r;
  logic             m_r;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             cf;
  logic             cout_r;
  logic             zero_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic [SLICE-1:0] a_sl;
  logic [SLICE-1:0] b_sl;
  logic [SLICE-1:0] t1;
  logic [SLICE-1:0] t2;
  logic [SLICE:0]   sum;
  logic [SLICE-1:0] res;
  logic             c_out;
  logic             c_msb;
  logic [WIDTH-1:0] f_shift;

  // Slice datapath. Operand copies are shifted right each RUN cycle so the
  // current slice is always in the low bits; the result is shifted in from
  // the top, so after N slices every slice sits at idx*SLICE.
  always_comb begin
    a_sl    = a_r[SLICE-1:0];
    b_sl    = b_r[SLICE-1:0];
    t1      = a_sl | ({SLICE{s_r[0]}} & b_sl) | ({SLICE{s_r[1]}} & ~b_sl);
    t2      = ({SLICE{s_r[2]}} & a_sl & ~b_sl) | ({SLICE{s_r[3]}} & a_sl & b_sl);
    sum     = {1'b0, t1} + {1'b0, t2} + {{SLICE{1'b0}}, carry};
    res     = m_r ? ~(t1 ^ t2) : sum[SLICE-1:0];
    c_out   = m_r ? 1'b0 : sum[SLICE];
    c_msb   = t1[SLICE-1] ^ t2[SLICE-1] ^ sum[SLICE-1];
    f_shift = f_r >> SLICE;
    f_shift[WIDTH-1 -: SLICE] = res;
  end

  // Control FSM with registered handshake outputs, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      f_r         <= '0;
      s_r         <= '0;
      m_r         <= 1'b0;
      carry       <= 1'b0;
      idx         <= '0;
      cf          <= 1'b0;
      cout_r      <= 1'b0;
      zero_r      <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            s_r        <= bus.s;
            m_r        <= bus.m;
            carry      <= bus.use_cf ? cf : bus.cin;
            idx        <= '0;
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          a_r   <= a_r >> SLICE;
          b_r   <= b_r >> SLICE;
          f_r   <= f_shift;
          carry <= c_out;
          if (idx == LAST) begin
            cout_r      <= c_out;
            zero_r      <= (f_shift == '0);
            ovf_r       <= m_r ? 1'b0 : (c_msb ^ c_out);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            if (!m_r) begin
              cf <= cout_r;
            end
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.f         = f_r;
  assign bus.cout      = cout_r;
  assign bus.zero      = zero_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_seq_slice_alu.sv
// Testbench for seq_slice_alu: table of directed operations run back to back
// (the stored carry flag threads through them), plus backpressure, reset
// abort and single-slice (WIDTH == SLICE) sequences.
`timescale 1ns/1ps
module tb_seq_slice_alu;

  localparam int unsigned WIDTH = 16;
  localparam int NVEC = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seq_slice_alu_if #(.WIDTH(WIDTH)) bus ();
  seq_slice_alu #(.WIDTH(WIDTH), .SLICE(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  seq_slice_alu_if #(.WIDTH(4)) bus4 ();
  seq_slice_alu #(.WIDTH(4), .SLICE(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin;
    logic        use_cf;
    logic [15:0] f;
    logic        cout;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t  vecs [NVEC];
  vec_t  tmp;
  int    checks   = 0;
  int    failures = 0;
  string tag;

  function automatic vec_t mk(input logic [15:0] a, input logic [15:0] b,
                              input logic [3:0] s, input logic m,
                              input logic cin, input logic use_cf,
                              input logic [15:0] f, input logic cout,
                              input logic zero, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.m = m; v.cin = cin; v.use_cf = use_cf;
    v.f = f; v.cout = cout; v.zero = zero; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Present a request one edge, then scramble the inputs to prove latching.
  task automatic start_op(input vec_t v, input string t);
    bus.a        = v.a;
    bus.b        = v.b;
    bus.s        = v.s;
    bus.m        = v.m;
    bus.cin      = v.cin;
    bus.use_cf   = v.use_cf;
    bus.in_valid = 1'b1;
    chk({t, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.s        = 4'($urandom);
    bus.m        = 1'($urandom);
    bus.cin      = 1'($urandom);
    bus.use_cf   = 1'($urandom);
  endtask

  task automatic wait_result(input int exp_lat, input string t);
    int lat;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({t, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_result(input vec_t v, input string t);
    chk({t, "_f"},    32'(bus.f),    32'(v.f));
    chk({t, "_cout"}, 32'(bus.cout), 32'(v.cout));
    chk({t, "_zero"}, 32'(bus.zero), 32'(v.zero));
    chk({t, "_ovf"},  32'(bus.ovf),  32'(v.ovf));
  endtask

  task automatic consume(input string t);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({t, "_out_valid_after"}, 32'(bus.out_valid), 32'd0);
    chk({t, "_in_ready_after"},  32'(bus.in_ready),  32'd1);
  endtask

  task automatic run_op(input vec_t v, input string t);
    start_op(v, t);
    wait_result(4, t);
    check_result(v, t);
    consume(t);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0; bus.out_ready  = 1'b0;
    bus.a = '0; bus.b = '0; bus.s = '0; bus.m = 1'b0; bus.cin = 1'b0; bus.use_cf = 1'b0;
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b0;
    bus4.a = '0; bus4.b = '0; bus4.s = '0; bus4.m = 1'b0; bus4.cin = 1'b0; bus4.use_cf = 1'b0;

    // a, b, s, m, cin, use_cf -> f, cout, zero, ovf (cf threads through in order)
    vecs[0]  = mk(16'h1234, 16'h0FFF, 4'b1001, 0, 0, 0, 16'h2233, 0, 0, 0);
    vecs[1]  = mk(16'h0005, 16'h0007, 4'b0110, 0, 1, 0, 16'hFFFE, 0, 0, 0);
    vecs[2]  = mk(16'h7FFF, 16'hFFFF, 4'b0110, 0, 1, 0, 16'h8000, 0, 0, 1);
    vecs[3]  = mk(16'hFFFF, 16'h0001, 4'b1001, 0, 0, 0, 16'h0000, 1, 1, 0);
    vecs[4]  = mk(16'h0000, 16'h0000, 4'b1001, 0, 0, 1, 16'h0001, 0, 0, 0);
    vecs[5]  = mk(16'h8000, 16'h8000, 4'b1001, 0, 0, 0, 16'h0000, 1, 1, 1);
    vecs[6]  = mk(16'hF0F0, 16'hFF00, 4'b0110, 1, 0, 0, 16'h0FF0, 0, 0, 0);
    vecs[7]  = mk(16'h0000, 16'h0000, 4'b1001, 0, 0, 1, 16'h0001, 0, 0, 0);
    vecs[8]  = mk(16'h0010, 16'h1234, 4'b1111, 0, 0, 0, 16'h000F, 1, 0, 0);
    vecs[9]  = mk(16'h5555, 16'hAAAA, 4'b0011, 0, 0, 0, 16'hFFFF, 0, 0, 0);
    vecs[10] = mk(16'h0001, 16'h0001, 4'b1001, 0, 1, 1, 16'h0002, 0, 0, 0);
    vecs[11] = mk(16'h4000, 16'h1234, 4'b1100, 0, 0, 0, 16'h8000, 0, 0, 1);
    vecs[12] = mk(16'h00FF, 16'h1234, 4'b0000, 1, 0, 0, 16'hFF00, 0, 0, 0);
    vecs[13] = mk(16'h1234, 16'h1234, 4'b1001, 1, 1, 0, 16'hFFFF, 0, 0, 0);
    vecs[14] = mk(16'hABCD, 16'h1357, 4'b0011, 1, 0, 0, 16'h0000, 0, 1, 0);
    vecs[15] = mk(16'h0001, 16'h0001, 4'b1001, 0, 1, 0, 16'h0003, 0, 0, 0);

    // Reset values
    #12;
    chk("rst_f",         32'(bus.f),         32'd0);
    chk("rst_cout",      32'(bus.cout),      32'd0);
    chk("rst_zero",      32'(bus.zero),      32'd0);
    chk("rst_ovf",       32'(bus.ovf),       32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      tag = $sformatf("v%0d", i);
      run_op(vecs[i], tag);
    end

    // Backpressure: in_valid pulses during RUN and DONE must be ignored
    tmp = mk(16'h1111, 16'h2222, 4'b1001, 0, 0, 0, 16'h3333, 0, 0, 0);
    start_op(tmp, "bp");
    bus.in_valid = 1'b1;
    bus.a = 16'hFFFF; bus.b = 16'hFFFF; bus.s = 4'b1001; bus.m = 1'b0;
    wait_result(4, "bp");
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = k[0];
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_f", k),         32'(bus.f),         32'h3333);
      chk($sformatf("bp_hold%0d_zero", k),      32'(bus.zero),      32'd0);
      chk($sformatf("bp_hold%0d_out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp_hold%0d_in_ready", k),  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid = 1'b0;
    consume("bp");
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_no_dup%0d", k), 32'(bus.out_valid), 32'd0);
    end
    bus.out_ready = 1'b0;
    run_op(vecs[0], "after_bp");

    // Reset during slice 2 aborts the op and clears cf
    run_op(vecs[3], "pre_rst");
    tmp = mk(16'h1234, 16'h1111, 4'b1001, 0, 0, 0, 16'h2345, 0, 0, 0);
    start_op(tmp, "abort");
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_f",         32'(bus.f),         32'd0);
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("abort_idle_out_valid", 32'(bus.out_valid), 32'd0);
    run_op(mk(16'h0000, 16'h0000, 4'b1001, 0, 0, 1, 16'h0000, 0, 1, 0), "cf_cleared");
    run_op(mk(16'h0001, 16'h0001, 4'b1001, 0, 0, 0, 16'h0002, 0, 0, 0), "post_rst");

    // Single-slice instance: accepted at E0, result valid right after E1
    bus4.a = 4'h9; bus4.b = 4'h8; bus4.s = 4'b1001; bus4.m = 1'b0;
    bus4.cin = 1'b0; bus4.use_cf = 1'b0; bus4.in_valid = 1'b1;
    chk("n1_in_ready", 32'(bus4.in_ready), 32'd1);
    @(posedge clk); #1;
    bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
    chk("n1_out_valid_e0", 32'(bus4.out_valid), 32'd0);
    @(posedge clk); #1;
    chk("n1_out_valid_e1", 32'(bus4.out_valid), 32'd1);
    chk("n1_f",    32'(bus4.f),    32'h1);
    chk("n1_cout", 32'(bus4.cout), 32'd1);
    chk("n1_zero", 32'(bus4.zero), 32'd0);
    chk("n1_ovf",  32'(bus4.ovf),  32'd1);
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    chk("n1_out_valid_after", 32'(bus4.out_valid), 32'd0);
    chk("n1_in_ready_after",  32'(bus4.in_ready),  32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
